// File: rtl/clk_pkg.sv
// Shared selection codes, switchover FSM states and default divides
// for the CPU clock generator.
package clk_pkg;

  localparam logic [1:0] SEL_50M = 2'b11;
  localparam logic [1:0] SEL_31K = 2'b10;
  localparam logic [1:0] SEL_2M  = 2'b01;
  localparam logic [1:0] SEL_250 = 2'b00;

  typedef enum logic [1:0] {
    RUN,
    WAIT_OLD_LOW,
    HOLD,
    WAIT_NEW_LOW
  } clk_state_e;

  localparam int DIV_50M_DEF  = 5;
  localparam int DIV_2M_DEF   = 125;
  localparam int DIV_31K_DEF  = 8000;
  localparam int DIV_250_DEF  = 1000000;
  localparam int DEBOUNCE_DEF = 250000;
  localparam int HOLD_CYC_DEF = 4;

  // src is packed so that the selection code indexes its source
  function automatic logic pick_src(
    input logic [1:0] sel,
    input logic [3:0] src
  );
    return src[sel];
  endfunction

endpackage

// File: rtl/clk_div_sq.sv
// Free-running divide-by-D square wave: high for floor(D/2) counts,
// low for the rest, registered output.
module clk_div_sq #(
  parameter int D = 5
) (
  input  logic clk,
  input  logic rst_n,
  output logic q
);

  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);
  localparam logic [CW-1:0] HALF = CW'(D / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;

  // next count wraps D-1 -> 0; output decodes current count
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    q_d   = (cnt_q < HALF);
  end

  // counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cpu_clock_gen.sv
// CPU source clock dividers plus glitch-free switchover onto cpuclk.
// Optional switch debounce: define CLKSW_DEBOUNCE_EN.
module cpu_clock_gen
  import clk_pkg::*;
#(
  parameter int DIV_50M  = DIV_50M_DEF,
  parameter int DIV_2M   = DIV_2M_DEF,
  parameter int DIV_31K  = DIV_31K_DEF,
  parameter int DIV_250  = DIV_250_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic       pll0_250MHz,
  input  logic       n_reset,
  input  logic [1:0] sw,
  output logic       MHz50,
  output logic       MHz2,
  output logic       KHz31,
  output logic       Hz250,
  output logic       cpuclk,
  output logic       cpuclk_rise,
  output logic [1:0] sel_active,
  output logic       switching
);

  localparam int HW = $clog2(HOLD_CYC + 1);

  if (HOLD_CYC < 1 || DEBOUNCE < 1) begin : g_bad_cfg
    $error("HOLD_CYC and DEBOUNCE must be at least 1");
  end

  clk_div_sq #(.D(DIV_50M)) u_div_50m (
    .clk(pll0_250MHz), .rst_n(n_reset), .q(MHz50));
  clk_div_sq #(.D(DIV_2M)) u_div_2m (
    .clk(pll0_250MHz), .rst_n(n_reset), .q(MHz2));
  clk_div_sq #(.D(DIV_31K)) u_div_31k (
    .clk(pll0_250MHz), .rst_n(n_reset), .q(KHz31));
  clk_div_sq #(.D(DIV_250)) u_div_250 (
    .clk(pll0_250MHz), .rst_n(n_reset), .q(Hz250));

  logic [1:0] sw_m_q, sw_s_q;
  logic [1:0] sw_s, sw_q;

  // two-flop synchronizer for the raw switches
  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      sw_m_q <= 2'b00;
      sw_s_q <= 2'b00;
    end else begin
      sw_m_q <= sw;
      sw_s_q <= sw_m_q;
    end
  end

  assign sw_s = sw_s_q;

`ifdef CLKSW_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE + 1);

  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]    sw_last_q, sw_last_d;
  logic [1:0]    sw_qual_q, sw_qual_d;

  // restart stability count on any change, accept once it saturates
  always_comb begin
    sw_last_d = sw_s;
    deb_cnt_d = deb_cnt_q;
    sw_qual_d = sw_qual_q;
    if (sw_s != sw_last_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DW'(DEBOUNCE - 1)) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end else begin
      sw_qual_d = sw_last_q;
    end
  end

  // debounce state registers
  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      deb_cnt_q <= '0;
      sw_last_q <= 2'b00;
      sw_qual_q <= 2'b00;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      sw_last_q <= sw_last_d;
      sw_qual_q <= sw_qual_d;
    end
  end

  assign sw_q = sw_qual_q;
`else
  assign sw_q = sw_s;
`endif

  clk_state_e    state_q, state_d;
  logic [1:0]    target_q, target_d;
  logic [1:0]    sel_q, sel_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          cpuclk_q, cpuclk_d;
  logic          rise_q, rise_d;
  logic [3:0]    src_vec;
  logic          cur_src;

  assign src_vec = {MHz50, KHz31, MHz2, Hz250};
  assign cur_src = pick_src(sel_q, src_vec);

  // switchover FSM; cpuclk may only fall once a change is pending
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    cpuclk_d = cur_src;
    unique case (state_q)
      RUN: begin
        if (sw_q != sel_q) begin
          target_d = sw_q;
          cpuclk_d = cpuclk_q & cur_src;
          state_d  = WAIT_OLD_LOW;
        end
      end
      WAIT_OLD_LOW: begin
        cpuclk_d = cpuclk_q & cur_src;
        if (!cur_src) begin
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        cpuclk_d = 1'b0;
        hold_d   = hold_q + HW'(1);
        if (hold_q == HW'(HOLD_CYC - 1)) begin
          sel_d   = target_q;
          state_d = WAIT_NEW_LOW;
        end
      end
      WAIT_NEW_LOW: begin
        cpuclk_d = 1'b0;
        if (!cur_src) begin
          state_d = RUN;
        end
      end
      default: begin
        cpuclk_d = 1'b0;
        state_d  = RUN;
      end
    endcase
    rise_d = cpuclk_d & ~cpuclk_q;
  end

  // FSM, selection and output registers
  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= RUN;
      target_q <= SEL_250;
      sel_q    <= SEL_250;
      hold_q   <= '0;
      cpuclk_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      hold_q   <= hold_d;
      cpuclk_q <= cpuclk_d;
      rise_q   <= rise_d;
    end
  end

  assign cpuclk      = cpuclk_q;
  assign cpuclk_rise = rise_q;
  assign sel_active  = sel_q;
  assign switching   = (state_q != RUN);

endmodule

// File: tb/tb_cpu_clock_gen.sv
// Scoreboard bench for cpu_clock_gen with small divide ratios.
// Stimulus queues expected selections; a monitor checks every cycle.
module tb_cpu_clock_gen;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [1:0] sw = 2'b00;
  logic       MHz50, MHz2, KHz31, Hz250;
  logic       cpuclk, cpuclk_rise, switching;
  logic [1:0] sel_active;

  int checks = 0;
  int errors = 0;
  int sw_cycles = 0;
  logic [1:0] exp_q[$];

  cpu_clock_gen #(
    .DIV_50M(5), .DIV_2M(10), .DIV_31K(20), .DIV_250(40),
    .DEBOUNCE(8), .HOLD_CYC(4)
  ) dut (
    .pll0_250MHz(clk),
    .n_reset(n_reset),
    .sw(sw),
    .MHz50(MHz50),
    .MHz2(MHz2),
    .KHz31(KHz31),
    .Hz250(Hz250),
    .cpuclk(cpuclk),
    .cpuclk_rise(cpuclk_rise),
    .sel_active(sel_active),
    .switching(switching)
  );

  always #2 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s got %0d want >= %0d at %0t", name, act, min, $time);
    end
  endtask

  function automatic logic src_of(input logic [1:0] s);
    case (s)
      2'b11:   return MHz50;
      2'b10:   return KHz31;
      2'b01:   return MHz2;
      default: return Hz250;
    endcase
  endfunction

  // monitor state
  int   hi_len[4] = '{2, 5, 10, 20};
  int   lo_len[4] = '{3, 5, 10, 20};
  logic prev_d[4];
  int   run_d[4];
  bit   seen_d[4];
  logic prev_clk, prev_sw, prev_src;
  bit   prev_valid, seen_c;
  int   run_c, sw_low;

  always @(negedge clk) begin
    logic [3:0] dv;
    dv = {Hz250, KHz31, MHz2, MHz50};
    if (!n_reset) begin
      for (int i = 0; i < 4; i++) begin
        prev_d[i] = 1'b0;
        run_d[i]  = 0;
        seen_d[i] = 1'b0;
      end
      prev_clk   = 1'b0;
      prev_sw    = 1'b0;
      prev_src   = 1'b0;
      prev_valid = 1'b0;
      seen_c     = 1'b0;
      run_c      = 0;
      sw_low     = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (dv[i] != prev_d[i]) begin
          if (seen_d[i])
            check($sformatf("div%0d_run", i), run_d[i],
                  prev_d[i] ? hi_len[i] : lo_len[i]);
          seen_d[i] = 1'b1;
          run_d[i]  = 1;
        end else begin
          run_d[i]++;
        end
        prev_d[i] = dv[i];
      end
      check("rise", cpuclk_rise, cpuclk & ~prev_clk);
      if (switching) begin
        sw_cycles++;
        check("rise_sw", cpuclk_rise, 1'b0);
        if (!cpuclk) sw_low++;
      end
      if (prev_valid && !switching && !prev_sw)
        check("track", cpuclk, prev_src);
      if (cpuclk != prev_clk) begin
        if (seen_c) begin
          if (prev_clk) check_ge("cpu_hi", run_c, 2);
          else          check_ge("cpu_lo", run_c, 3);
        end
        seen_c = 1'b1;
        run_c  = 1;
      end else begin
        run_c++;
      end
      if (prev_sw && !switching) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sel_unexpected got %0h want none", sel_active);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          checks--;
          check("sel_done", sel_active, e);
        end
        check_ge("hold_low", sw_low, 4);
        sw_low = 0;
      end
      prev_clk   = cpuclk;
      prev_sw    = switching;
      prev_src   = src_of(sel_active);
      prev_valid = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !switching) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout got pending %0d want 0", name, exp_q.size());
    end
  endtask

  task automatic go(input logic [1:0] v, input string name);
    exp_q.push_back(v);
    sw = v;
    wait_done(name, 400);
    check({name, "_sel"}, sel_active, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base;
    bit hit;
    n_reset = 1'b0;
    sw = 2'b00;
    cyc(5);
    check("rst_out",
          {MHz50, MHz2, KHz31, Hz250, cpuclk, cpuclk_rise,
           sel_active, switching}, 0);
    n_reset = 1'b1;
    cyc(200);
    check("idle_no_switch", sw_cycles, 0);
    check("idle_sel", sel_active, 2'b00);

    go(2'b11, "to_50m");
    cyc(30);

    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = MHz50;
    end
    check("m50_high_found", hit, 1'b1);
    go(2'b10, "to_31k");
    cyc(20);
    go(2'b00, "to_250");
    cyc(20);

    base = sw_cycles;
`ifdef CLKSW_DEBOUNCE_EN
    sw = 2'b01;
    cyc(5);
    sw = 2'b00;
    cyc(60);
    check("glitch_no_switch", sw_cycles - base, 0);
    check("glitch_sel", sel_active, 2'b00);
`else
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    sw = 2'b01;
    cyc(5);
    sw = 2'b00;
    wait_done("glitch", 600);
    check("glitch_sel", sel_active, 2'b00);
    check_ge("glitch_switched", sw_cycles - base, 8);
`endif

    exp_q.push_back(2'b11);
    sw = 2'b11;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = switching;
    end
    check("hold_sw_start", hit, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = switching & ~cpuclk;
    end
    check("hold_reached", hit, 1'b1);
    @(negedge clk);
    #1 n_reset = 1'b0;
    #1;
    check("async_rst_out",
          {MHz50, MHz2, KHz31, Hz250, cpuclk, cpuclk_rise,
           sel_active, switching}, 0);
    exp_q.delete();
    sw = 2'b00;
    cyc(3);
    n_reset = 1'b1;
    base = sw_cycles;
    cyc(60);
    check("post_rst_sel", sel_active, 2'b00);
    check("post_rst_run", sw_cycles - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
